crc32_fcs_engine: RTL and testbench
===================================

Name: crc32_fcs_engine

Overview:
- Parametrised successor to the byte-stream CRC-32 checker.
- Sits between the MAC byte pipeline and the framing logic.
- CHECK mode: validates the trailing FCS of each received packet, optionally strips the 4 FCS bytes, and flags mismatch on the EOP beat.
- GENERATE mode: computes the FCS over a transmit payload and appends it as 4 extra beats.
- Full valid/ready backpressure on both sides (the previous block had none).

Parameters:
- MODE, 0, 0 = CHECK, 1 = GENERATE.
- POLY, 32'h04C11DB7, generator polynomial (normal form, MSB-first register).
- INIT, 32'hFFFFFFFF, register value loaded on every SOP beat.
- RESIDUE, 32'hC704DD7B, CHECK mode: expected raw register value after the last FCS byte.
- REFLECT_IN, 1, 1 = bit-reverse each input byte before feeding the register.
- XOR_OUT, 32'hFFFFFFFF, GENERATE mode: XOR applied to the register before FCS emission.
- STRIP_FCS, 1, CHECK mode: 1 = remove the 4 FCS bytes from the output stream; ignored when MODE=1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stream_in_startofpacket  in  1  first byte of packet
- stream_in_endofpacket  in  1  last byte of packet
- stream_in_valid  in  1  input beat valid
- stream_in_ready  out  1  engine accepts beat when valid&&ready
- stream_in_data  in  8  payload byte
- stream_in_error  in  1  upstream error, carried to EOP
- stream_out_startofpacket  out  1  first output byte
- stream_out_endofpacket  out  1  last output byte
- stream_out_valid  out  1  output beat valid
- stream_out_ready  in  1  downstream accepts when valid&&ready
- stream_out_data  out  8  output byte
- stream_out_error  out  1  EOP-qualified error (upstream OR CRC fail)

Behaviour:
- Reset: asynchronous, active-low. All outputs 0, stream_in_ready 0 while rst_n=0. CRC register = INIT, FSM = IDLE, delay line empty, sticky error cleared.
  - Reset asserted mid-packet discards the packet silently; no partial EOP is emitted.
- Handshake:
  - Input accepted on valid&&ready. Output held stable while out_valid && !out_ready.
  - Output stage is a single register: stream_in_ready = (!out_valid || stream_out_ready), gated by FSM.
- CRC update: one byte per accepted beat.
  - Register update is the parallel 8-step LFSR of POLY on the (optionally reflected) byte.
  - An SOP beat computes from INIT regardless of the current register (restart allowed mid-packet).
- Error accumulation: stream_in_error ORed into a sticky flag over the packet; flag cleared on SOP.
- CHECK, STRIP_FCS=0:
  - Latency 1 cycle; pass-through.
  - On the EOP beat, out_error = sticky | in_error | (crc_next != RESIDUE).
- CHECK, STRIP_FCS=1:
  - 4-byte delay line (with SOP tags). A byte is emitted only once 4 newer bytes of the packet have been accepted; the delay line is never output.
  - On input EOP, the oldest held byte is emitted with EOP=1 and error as above; remaining 4 held bytes are discarded.
  - Packet of ≤4 bytes: no payload exists. Emit nothing and count the packet in no output; the drop is silent but its error cannot be reported.
  - SOP arriving while the delay line holds bytes flushes them (dropped, never emitted).
- GENERATE FSM states: IDLE -> DATA -> FCS0 -> FCS1 -> FCS2 -> FCS3 -> IDLE.
  - SOP accepted: IDLE/any -> DATA.
  - Payload beats pass through with latency 1; EOP is suppressed on output.
  - On EOP accepted -> FCS0; stream_in_ready=0 throughout FCS0..FCS3.
  - FCS value f = bitrev32(crc ^ XOR_OUT) when REFLECT_IN=1, else crc ^ XOR_OUT.
  - Bytes are emitted f[7:0], f[15:8], f[23:16], f[31:24]. FCS3 carries EOP=1 and error=sticky.
  - Each FCS state advances only on an output handshake.
  - Single-byte packet (SOP&&EOP): 1 payload beat + 4 FCS beats.
- Simultaneous events:
  - Output stall on an EOP beat holds the error/EOP value stable.
  - A new SOP cannot enter during FCS states; it is backpressured.
- Valid without a preceding SOP (IDLE): byte passes with the CRC computed from the current register; no error is generated.

Test Plan:
- GENERATE: ASCII "123456789" (SOP on '1', EOP on '9'), out_ready=1 -> outputs 31..39 then 26 39 F4 CB; EOP only on CB; 13 output beats; error=0.
- CHECK, STRIP_FCS=1: input "123456789" + 26 39 F4 CB -> outputs 31..39; EOP on 39, error=0; no FCS bytes appear.
- CHECK, STRIP_FCS=1, corrupted FCS (27 39 F4 CB) -> same 9 bytes; EOP byte 39 with error=1.
- Backpressure: GENERATE, stream_out_ready toggled 1/0 every cycle -> identical byte sequence to the first scenario; stream_in_ready=0 during all 4 FCS beats; no byte dropped or duplicated.
- Upstream error: CHECK with valid FCS, stream_in_error=1 on byte 3 only -> EOP error=1. The next packet with no error reports error=0 (sticky cleared on SOP).
- Reset mid-packet: assert rst_n=0 after byte 5 of a GENERATE packet -> all outputs 0 immediately. A fresh "123456789" after release yields FCS 26 39 F4 CB.

Source files
------------

// File: rtl/crc32_fcs_engine.sv
// CRC-32 FCS engine for the MAC byte stream: checks (and optionally strips) the
// trailing FCS on receive, or appends a computed FCS on transmit.
module crc32_fcs_engine #(
  parameter int unsigned MODE       = 0,
  parameter logic [31:0] POLY       = 32'h04C11DB7,
  parameter logic [31:0] INIT       = 32'hFFFFFFFF,
  parameter logic [31:0] RESIDUE    = 32'hC704DD7B,
  parameter bit          REFLECT_IN = 1'b1,
  parameter logic [31:0] XOR_OUT    = 32'hFFFFFFFF,
  parameter bit          STRIP_FCS  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stream_in_startofpacket,
  input  logic       stream_in_endofpacket,
  input  logic       stream_in_valid,
  output logic       stream_in_ready,
  input  logic [7:0] stream_in_data,
  input  logic       stream_in_error,
  output logic       stream_out_startofpacket,
  output logic       stream_out_endofpacket,
  output logic       stream_out_valid,
  input  logic       stream_out_ready,
  output logic [7:0] stream_out_data,
  output logic       stream_out_error
);

  typedef enum logic [2:0] {IDLE, DATA, FCS0, FCS1, FCS2, FCS3} state_t;

  localparam bit GEN   = (MODE == 1);
  localparam bit STRIP = !GEN && STRIP_FCS;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] din);
    logic [31:0] c;
    logic [7:0]  d;
    logic        fb;
    c = crc_in;
    for (int i = 0; i < 8; i++) d[i] = REFLECT_IN ? din[7-i] : din[i];
    for (int i = 7; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
    return c;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [31:0]     crc_q, crc_next, fcs_raw, fcs_val;
  logic            err_q, sticky_base, check_err;
  logic [3:0][7:0] dl_data;
  logic [3:0]      dl_sop;

  logic            out_valid_q, out_sop_q, out_eop_q, out_err_q;
  logic [7:0]      out_data_q;

  logic            out_free, gen_busy, in_ready_c, in_fire;
  logic            load, ld_sop, ld_eop, ld_err;
  logic [7:0]      ld_data;

  assign out_free   = !out_valid_q || stream_out_ready;
  assign gen_busy   = GEN && (state_q inside {FCS0, FCS1, FCS2, FCS3});
  assign in_ready_c = rst_n && out_free && !gen_busy;
  assign in_fire    = stream_in_valid && in_ready_c;

  // SOP restarts the CRC from INIT and clears the sticky error on the same beat.
  always_comb begin
    crc_next    = crc_byte(stream_in_startofpacket ? INIT : crc_q, stream_in_data);
    sticky_base = stream_in_startofpacket ? 1'b0 : err_q;
    check_err   = sticky_base | stream_in_error | (crc_next != RESIDUE);
    fcs_raw     = crc_q ^ XOR_OUT;
    fcs_val     = REFLECT_IN ? bitrev32(fcs_raw) : fcs_raw;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    ld_data = stream_in_data;
    ld_sop  = stream_in_startofpacket;
    ld_eop  = 1'b0;
    ld_err  = 1'b0;
    if (GEN) begin
      case (state_q)
        FCS0: if (out_free) begin
          load = 1'b1; ld_sop = 1'b0; ld_data = fcs_val[7:0];   state_d = FCS1;
        end
        FCS1: if (out_free) begin
          load = 1'b1; ld_sop = 1'b0; ld_data = fcs_val[15:8];  state_d = FCS2;
        end
        FCS2: if (out_free) begin
          load = 1'b1; ld_sop = 1'b0; ld_data = fcs_val[23:16]; state_d = FCS3;
        end
        FCS3: if (out_free) begin
          load = 1'b1; ld_sop = 1'b0; ld_data = fcs_val[31:24];
          ld_eop = 1'b1; ld_err = err_q; state_d = IDLE;
        end
        default: if (in_fire) begin
          load = 1'b1;
          if (stream_in_endofpacket)        state_d = FCS0;
          else if (stream_in_startofpacket) state_d = DATA;
        end
      endcase
    end else if (STRIP) begin
      // A byte leaves only once four newer bytes prove it is not part of the FCS.
      if (in_fire) begin
        if (stream_in_startofpacket) begin
          cnt_d = stream_in_endofpacket ? 3'd0 : 3'd1;
        end else if (cnt_q == 3'd4) begin
          load    = 1'b1;
          ld_data = dl_data[3];
          ld_sop  = dl_sop[3];
          ld_eop  = stream_in_endofpacket;
          ld_err  = stream_in_endofpacket && check_err;
          cnt_d   = stream_in_endofpacket ? 3'd0 : 3'd4;
        end else begin
          cnt_d = stream_in_endofpacket ? 3'd0 : cnt_q + 3'd1;
        end
      end
    end else begin
      if (in_fire) begin
        load   = 1'b1;
        ld_eop = stream_in_endofpacket;
        ld_err = stream_in_endofpacket && check_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q   <= INIT;
      err_q   <= 1'b0;
      dl_data <= '0;
      dl_sop  <= '0;
    end else if (in_fire) begin
      crc_q   <= crc_next;
      err_q   <= sticky_base | stream_in_error;
      dl_data <= {dl_data[2:0], stream_in_data};
      dl_sop  <= {dl_sop[2:0], stream_in_startofpacket};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_data_q  <= 8'h00;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_sop_q   <= ld_sop;
      out_eop_q   <= ld_eop;
      out_err_q   <= ld_err;
      out_data_q  <= ld_data;
    end else if (stream_out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign stream_in_ready          = in_ready_c;
  assign stream_out_valid         = out_valid_q;
  assign stream_out_startofpacket = out_sop_q;
  assign stream_out_endofpacket   = out_eop_q;
  assign stream_out_error         = out_err_q;
  assign stream_out_data          = out_data_q;

endmodule

// File: tb/tb_crc32_fcs_engine.sv
// Directed bench for crc32_fcs_engine: one GENERATE instance and one CHECK
// instance with FCS stripping, driven from a single linear stimulus sequence.
module tb_crc32_fcs_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       g_in_sop, g_in_eop, g_in_valid, g_in_ready, g_in_err;
  logic [7:0] g_in_data;
  logic       g_out_sop, g_out_eop, g_out_valid, g_out_ready, g_out_err;
  logic [7:0] g_out_data;

  logic       c_in_sop, c_in_eop, c_in_valid, c_in_ready, c_in_err;
  logic [7:0] c_in_data;
  logic       c_out_sop, c_out_eop, c_out_valid, c_out_ready, c_out_err;
  logic [7:0] c_out_data;

  crc32_fcs_engine #(.MODE(1)) u_gen (
    .clk(clk), .rst_n(rst_n),
    .stream_in_startofpacket(g_in_sop), .stream_in_endofpacket(g_in_eop),
    .stream_in_valid(g_in_valid), .stream_in_ready(g_in_ready),
    .stream_in_data(g_in_data), .stream_in_error(g_in_err),
    .stream_out_startofpacket(g_out_sop), .stream_out_endofpacket(g_out_eop),
    .stream_out_valid(g_out_valid), .stream_out_ready(g_out_ready),
    .stream_out_data(g_out_data), .stream_out_error(g_out_err)
  );

  crc32_fcs_engine #(.MODE(0), .STRIP_FCS(1'b1)) u_chk (
    .clk(clk), .rst_n(rst_n),
    .stream_in_startofpacket(c_in_sop), .stream_in_endofpacket(c_in_eop),
    .stream_in_valid(c_in_valid), .stream_in_ready(c_in_ready),
    .stream_in_data(c_in_data), .stream_in_error(c_in_err),
    .stream_out_startofpacket(c_out_sop), .stream_out_endofpacket(c_out_eop),
    .stream_out_valid(c_out_valid), .stream_out_ready(c_out_ready),
    .stream_out_data(c_out_data), .stream_out_error(c_out_err)
  );

  int          errors = 0;
  int          checks = 0;
  int          viol   = 0;
  bit          bp     = 1'b0;
  bit          fcs_done;
  logic [10:0] g_q[$];
  logic [10:0] c_q[$];
  logic [10:0] exp_q[$];
  logic [7:0]  pkt[16];
  logic [7:0]  digits[9];
  logic [7:0]  fcs_b[4];

  // Beats are logged as {sop, eop, err, data} on every output handshake.
  always @(negedge clk) begin
    if (g_out_valid && g_out_ready) g_q.push_back({g_out_sop, g_out_eop, g_out_err, g_out_data});
    if (c_out_valid && c_out_ready) c_q.push_back({c_out_sop, c_out_eop, c_out_err, c_out_data});
  end

  function automatic logic [10:0] beat(input bit s, input bit e, input bit r, input logic [7:0] d);
    return {s, e, r, d};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp) g_out_ready = ~g_out_ready;
  endtask

  task automatic apply_stimulus(input bit to_chk, input logic [7:0] d,
                                input bit sop, input bit eop, input bit err);
    bit hs;
    int n;
    if (to_chk) begin
      c_in_valid = 1'b1; c_in_data = d; c_in_sop = sop; c_in_eop = eop; c_in_err = err;
    end else begin
      g_in_valid = 1'b1; g_in_data = d; g_in_sop = sop; g_in_eop = eop; g_in_err = err;
    end
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 100) begin
      @(negedge clk);
      hs = to_chk ? (c_in_valid && c_in_ready) : (g_in_valid && g_in_ready);
      tick();
      n++;
    end
    c_in_valid = 1'b0; c_in_sop = 1'b0; c_in_eop = 1'b0; c_in_err = 1'b0;
    g_in_valid = 1'b0; g_in_sop = 1'b0; g_in_eop = 1'b0; g_in_err = 1'b0;
    check_output("in_accept", {31'd0, hs}, 32'd1);
  endtask

  task automatic send_packet(input bit to_chk, input int n, input int err_idx);
    for (int i = 0; i < n; i++)
      apply_stimulus(to_chk, pkt[i], i == 0, i == n - 1, i == err_idx);
  endtask

  // Runs a fixed window; for the generator it also notes any cycle where the
  // input is ready before the FCS EOP beat has appeared on the output.
  task automatic drain(input bit to_chk);
    fcs_done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!to_chk) begin
        if (g_out_valid && g_out_eop) fcs_done = 1'b1;
        else if (!fcs_done && g_in_ready) viol++;
      end
      tick();
    end
  endtask

  task automatic compare_q(input string tag, input bit to_chk);
    logic [10:0] got[$];
    int          m;
    if (to_chk) got = c_q;
    else        got = g_q;
    check_output({tag, "_count"}, got.size(), exp_q.size());
    m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      check_output($sformatf("%s[%0d]", tag, i), {21'd0, got[i]}, {21'd0, exp_q[i]});
  endtask

  task automatic expect_gen_frame();
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(beat(i == 0, 1'b0, 1'b0, digits[i]));
    for (int i = 0; i < 4; i++) exp_q.push_back(beat(1'b0, i == 3, 1'b0, fcs_b[i]));
  endtask

  task automatic expect_chk_frame(input bit err);
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(beat(i == 0, i == 8, (i == 8) && err, digits[i]));
  endtask

  task automatic load_check_pkt();
    for (int i = 0; i < 9; i++) pkt[i] = digits[i];
    for (int i = 0; i < 4; i++) pkt[9+i] = fcs_b[i];
  endtask

  initial begin
    digits = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    fcs_b  = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    rst_n = 1'b0;
    g_in_valid = 1'b0; g_in_sop = 1'b0; g_in_eop = 1'b0; g_in_err = 1'b0; g_in_data = 8'h00;
    c_in_valid = 1'b0; c_in_sop = 1'b0; c_in_eop = 1'b0; c_in_err = 1'b0; c_in_data = 8'h00;
    g_out_ready = 1'b1;
    c_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_gen", {19'd0, g_in_ready, g_out_valid, g_out_sop, g_out_eop, g_out_err, g_out_data}, 32'd0);
    check_output("reset_chk", {19'd0, c_in_ready, c_out_valid, c_out_sop, c_out_eop, c_out_err, c_out_data}, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] generate 123456789");
    for (int i = 0; i < 9; i++) pkt[i] = digits[i];
    g_q.delete();
    send_packet(1'b0, 9, -1);
    drain(1'b0);
    expect_gen_frame();
    compare_q("gen_basic", 1'b0);
    check_output("gen_basic_eop_seen", {31'd0, fcs_done}, 32'd1);

    $display("[TB] check good FCS with strip");
    load_check_pkt();
    c_q.delete();
    send_packet(1'b1, 13, -1);
    drain(1'b1);
    expect_chk_frame(1'b0);
    compare_q("chk_good", 1'b1);

    $display("[TB] check corrupted FCS");
    load_check_pkt();
    pkt[9] = 8'h27;
    c_q.delete();
    send_packet(1'b1, 13, -1);
    drain(1'b1);
    expect_chk_frame(1'b1);
    compare_q("chk_bad", 1'b1);

    $display("[TB] generate with output backpressure");
    for (int i = 0; i < 9; i++) pkt[i] = digits[i];
    g_q.delete();
    bp = 1'b1;
    send_packet(1'b0, 9, -1);
    drain(1'b0);
    bp = 1'b0;
    g_out_ready = 1'b1;
    tick();
    expect_gen_frame();
    compare_q("gen_bp", 1'b0);
    check_output("gen_ready_in_fcs", viol, 32'd0);

    $display("[TB] upstream error then clean packet");
    load_check_pkt();
    c_q.delete();
    send_packet(1'b1, 13, 2);
    drain(1'b1);
    expect_chk_frame(1'b1);
    compare_q("chk_uperr", 1'b1);
    c_q.delete();
    send_packet(1'b1, 13, -1);
    drain(1'b1);
    expect_chk_frame(1'b0);
    compare_q("chk_sticky_clr", 1'b1);

    $display("[TB] short packet is dropped");
    c_q.delete();
    send_packet(1'b1, 3, -1);
    drain(1'b1);
    check_output("chk_short_count", c_q.size(), 32'd0);

    $display("[TB] reset mid-packet");
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, digits[i], i == 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_output("reset_mid", {19'd0, g_in_ready, g_out_valid, g_out_sop, g_out_eop, g_out_err, g_out_data}, 32'd0);
    tick();
    tick();
    g_q.delete();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) pkt[i] = digits[i];
    send_packet(1'b0, 9, -1);
    drain(1'b0);
    expect_gen_frame();
    compare_q("gen_after_reset", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
